// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, state encoding and helpers for the nibble ALU sequencer
package alu_pkg;

   localparam int NIB_W = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOP = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PASS = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // Only ADD and SUB chain a carry/borrow between nibbles.
   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// rtl/alu_nibble_sequencer_if.sv - command, response and 4-bit ALU signals of the sequencer
// slave is the sequencer's view; master is the command source, response sink and ALU.
interface alu_nibble_sequencer_if #(parameter int NIBBLES = 2);

   localparam int W = 4 * NIBBLES;

   logic         cmd_valid;
   logic         cmd_ready;
   logic [2:0]   cmd_op;
   logic [W-1:0] cmd_a;
   logic [W-1:0] cmd_b;

   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_carry;
   logic         rsp_zero;

   logic [3:0]   alu_a;
   logic [3:0]   alu_b;
   logic [2:0]   alu_sel;
   logic [3:0]   alu_out;
   logic         alu_carry;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_out, alu_carry,
      output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, alu_a, alu_b, alu_sel
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_out, alu_carry,
      input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, alu_a, alu_b, alu_sel
   );

endinterface

// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - runs wide ADD/SUB/logic ops through an external 4-bit ALU
// One nibble per PASS cycle, LSB first; a pending carry costs one FIX cycle on the next nibble.
module alu_nibble_sequencer
   import alu_pkg::*;
#(
   parameter int NIBBLES = 2
) (
   input logic                  clk,
   input logic                  rst,
   alu_nibble_sequencer_if.slave bus
);

   localparam int W  = NIB_W * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   state_e        state_q;
   logic [IW-1:0] idx_q;
   logic [2:0]    op_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  res_q;
   logic [W-1:0]  res_d;
   logic          pend_q;
   logic          c1_q;
   logic          carry_q;
   logic          zero_q;
   logic [IW+1:0] bit_lo;
   logic          arith;
   logic          last;
   logic          fix_carry;

   assign bit_lo    = {idx_q, 2'b00};
   assign arith     = is_arith(op_q);
   assign last      = (idx_q == LAST_IDX);
   assign fix_carry = c1_q | bus.alu_carry;

   always_comb begin
      res_d = res_q;
      res_d[bit_lo +: NIB_W] = bus.alu_out;
   end

   always_comb begin
      bus.alu_a   = '0;
      bus.alu_b   = '0;
      bus.alu_sel = OP_NOP;
      if (state_q == S_PASS) begin
         bus.alu_a   = a_q[bit_lo +: NIB_W];
         bus.alu_b   = b_q[bit_lo +: NIB_W];
         bus.alu_sel = op_q;
      end else if (state_q == S_FIX) begin
         bus.alu_a   = res_q[bit_lo +: NIB_W];
         bus.alu_b   = 4'h1;
         bus.alu_sel = op_q;
      end
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_DONE);
   assign bus.rsp_data  = res_q;
   assign bus.rsp_carry = carry_q;
   assign bus.rsp_zero  = zero_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         op_q    <= OP_NOP;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         pend_q  <= 1'b0;
         c1_q    <= 1'b0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  op_q    <= bus.cmd_op;
                  a_q     <= bus.cmd_a;
                  b_q     <= bus.cmd_b;
                  idx_q   <= '0;
                  pend_q  <= 1'b0;
                  res_q   <= '0;
                  carry_q <= 1'b0;
                  zero_q  <= 1'b0;
                  state_q <= S_PASS;
               end
            end
            S_PASS: begin
               res_q <= res_d;
               c1_q  <= bus.alu_carry;
               if (arith && pend_q) begin
                  state_q <= S_FIX;
               end else begin
                  pend_q <= arith & bus.alu_carry;
                  if (last) begin
                     carry_q <= arith & bus.alu_carry;
                     zero_q  <= (res_d == '0);
                     state_q <= S_DONE;
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end
            end
            S_FIX: begin
               // The raw pass and the +1 correction can never both carry out.
               res_q  <= res_d;
               pend_q <= fix_carry;
               if (last) begin
                  carry_q <= fix_carry;
                  zero_q  <= (res_d == '0);
                  state_q <= S_DONE;
               end else begin
                  idx_q   <= idx_q + IW'(1);
                  state_q <= S_PASS;
               end
            end
            S_DONE: begin
               if (bus.rsp_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb/tb_alu_nibble_sequencer.sv - directed bench for alu_nibble_sequencer with a 4-bit ALU model
module tb_alu_nibble_sequencer;
   import alu_pkg::*;

   localparam int NIBBLES = 2;
   localparam int W = 4 * NIBBLES;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_nibble_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

   alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // External 4-bit ALU: bit 4 of the 5-bit result is the carry or borrow.
   logic [4:0] alu_sum;
   always_comb begin
      alu_sum = 5'd0;
      case (bus.alu_sel)
         OP_ADD:  alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
         OP_SUB:  alu_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
         OP_AND:  alu_sum = {1'b0, bus.alu_a & bus.alu_b};
         OP_OR:   alu_sum = {1'b0, bus.alu_a | bus.alu_b};
         OP_XOR:  alu_sum = {1'b0, bus.alu_a ^ bus.alu_b};
         default: alu_sum = 5'd0;
      endcase
   end
   assign bus.alu_out   = alu_sum[3:0];
   assign bus.alu_carry = alu_sum[4];

   logic [7:0] pass_log[$];
   always @(negedge clk) begin
      if (bus.alu_sel != OP_NOP) pass_log.push_back({bus.alu_a, bus.alu_b});
   end

   int compared = 0;
   int mismatched = 0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic accept_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             output bit ok);
      ok = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op = op;
      bus.cmd_a = a;
      bus.cmd_b = b;
      for (int i = 0; i < 40; i++) begin
         if (bus.cmd_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      bus.cmd_valid = 1'b0;
      pass_log.delete();
   endtask

   task automatic wait_rsp(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] data, output logic carry, output logic zero,
                         output int lat);
      bit ok;
      bus.rsp_ready = 1'b1;
      accept_cmd(op, a, b, ok);
      if (ok) wait_rsp(lat);
      else lat = -2;
      data = bus.rsp_data;
      carry = bus.rsp_carry;
      zero = bus.rsp_zero;
      if (bus.rsp_valid) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      bus.cmd_valid = 1'b0;
      bus.cmd_op = OP_ADD;
      bus.cmd_a = '0;
      bus.cmd_b = '0;
      bus.rsp_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_carry, bus.rsp_zero} !== 4'b1000) begin
         mismatched++;
         $display("FAIL reset_flags: got %b expected 1000",
                  {bus.cmd_ready, bus.rsp_valid, bus.rsp_carry, bus.rsp_zero});
      end
      compared++;
      if (bus.rsp_data !== 8'h00) begin
         mismatched++;
         $display("FAIL reset_data: got %h expected 00", bus.rsp_data);
      end
      compared++;
      if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== {4'h0, 4'h0, 3'b111}) begin
         mismatched++;
         $display("FAIL reset_alu_drive: got %h/%h/%b expected 0/0/111",
                  bus.alu_a, bus.alu_b, bus.alu_sel);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_add;
      logic [W-1:0] d;
      logic c, z;
      int lat;
      run_op(OP_ADD, 8'h3C, 8'h0F, d, c, z, lat);
      compared++;
      if ({d, c, z} !== {8'h4B, 1'b0, 1'b0}) begin
         mismatched++;
         $display("FAIL add_3c_0f: got %h c%b z%b expected 4b c0 z0", d, c, z);
      end
      compared++;
      if (lat !== 3) begin
         mismatched++;
         $display("FAIL add_3c_0f_latency: got %0d expected 3", lat);
      end
      compared++;
      if (pass_log.size() !== 3) begin
         mismatched++;
         $display("FAIL add_3c_0f_passes: got %0d expected 3", pass_log.size());
      end else if ({pass_log[0], pass_log[1], pass_log[2]} !== 24'hCF3031) begin
         mismatched++;
         $display("FAIL add_3c_0f_operands: got %h expected cf3031",
                  {pass_log[0], pass_log[1], pass_log[2]});
      end

      run_op(OP_ADD, 8'hFF, 8'h01, d, c, z, lat);
      compared++;
      if ({d, c, z} !== {8'h00, 1'b1, 1'b1}) begin
         mismatched++;
         $display("FAIL add_ff_01: got %h c%b z%b expected 00 c1 z1", d, c, z);
      end
      compared++;
      if (lat !== 3) begin
         mismatched++;
         $display("FAIL add_ff_01_latency: got %0d expected 3", lat);
      end
      compared++;
      if (pass_log.size() !== 3) begin
         mismatched++;
         $display("FAIL add_ff_01_passes: got %0d expected 3", pass_log.size());
      end else if ({pass_log[0], pass_log[1], pass_log[2]} !== 24'hF1F0F1) begin
         mismatched++;
         $display("FAIL add_ff_01_operands: got %h expected f1f0f1",
                  {pass_log[0], pass_log[1], pass_log[2]});
      end
   endtask

   task automatic test_sub;
      logic [W-1:0] ta[3] = '{8'h10, 8'h00, 8'h35};
      logic [W-1:0] tb[3] = '{8'h01, 8'h01, 8'h12};
      logic [W-1:0] td[3] = '{8'h0F, 8'hFF, 8'h23};
      logic         tc[3] = '{1'b0, 1'b1, 1'b0};
      int           tl[3] = '{3, 3, 2};
      logic [W-1:0] d;
      logic c, z;
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_op(OP_SUB, ta[i], tb[i], d, c, z, lat);
         compared++;
         if ({d, c, z} !== {td[i], tc[i], 1'b0}) begin
            mismatched++;
            $display("FAIL sub_%h_%h: got %h c%b z%b expected %h c%b z0",
                     ta[i], tb[i], d, c, z, td[i], tc[i]);
         end
         compared++;
         if (lat !== tl[i]) begin
            mismatched++;
            $display("FAIL sub_%h_%h_latency: got %0d expected %0d", ta[i], tb[i], lat, tl[i]);
         end
      end
   endtask

   task automatic test_logic;
      logic [2:0]   to[3] = '{OP_XOR, 3'b101, OP_AND};
      logic [W-1:0] ta[3] = '{8'hA5, 8'hFF, 8'hF0};
      logic [W-1:0] tb[3] = '{8'hFF, 8'hFF, 8'h0F};
      logic [W-1:0] td[3] = '{8'h5A, 8'h00, 8'h00};
      logic         tz[3] = '{1'b0, 1'b1, 1'b1};
      logic [W-1:0] d;
      logic c, z;
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_op(to[i], ta[i], tb[i], d, c, z, lat);
         compared++;
         if ({d, c, z} !== {td[i], 1'b0, tz[i]}) begin
            mismatched++;
            $display("FAIL logic_op%b: got %h c%b z%b expected %h c0 z%b",
                     to[i], d, c, z, td[i], tz[i]);
         end
         compared++;
         if (lat !== 2) begin
            mismatched++;
            $display("FAIL logic_op%b_latency: got %0d expected 2", to[i], lat);
         end
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      int lat;
      int bad;
      bus.rsp_ready = 1'b0;
      accept_cmd(OP_ADD, 8'h12, 8'h34, ok);
      wait_rsp(lat);
      compared++;
      if (lat !== 2 || {bus.rsp_data, bus.rsp_carry, bus.rsp_zero} !== {8'h46, 1'b0, 1'b0}) begin
         mismatched++;
         $display("FAIL stall_first: got lat %0d %h c%b z%b expected lat 2 46 c0 z0",
                  lat, bus.rsp_data, bus.rsp_carry, bus.rsp_zero);
      end
      // A second command is offered during the stall and must be ignored until IDLE.
      bus.cmd_valid = 1'b1;
      bus.cmd_op = OP_OR;
      bus.cmd_a = 8'h0F;
      bus.cmd_b = 8'hF0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_data, bus.rsp_carry, bus.rsp_zero}
             !== {1'b1, 1'b0, 8'h46, 1'b0, 1'b0}) bad++;
      end
      compared++;
      if (bad !== 0) begin
         mismatched++;
         $display("FAIL stall_hold: got %0d disturbed cycles expected 0", bad);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      compared++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
         mismatched++;
         $display("FAIL release_idle: got valid/ready %b expected 01", {bus.rsp_valid, bus.cmd_ready});
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      pass_log.delete();
      compared++;
      if (bus.cmd_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL b2b_accept: got cmd_ready %b expected 0", bus.cmd_ready);
      end
      wait_rsp(lat);
      compared++;
      if (lat !== 2 || {bus.rsp_data, bus.rsp_carry, bus.rsp_zero} !== {8'hFF, 1'b0, 1'b0}) begin
         mismatched++;
         $display("FAIL b2b_second: got lat %0d %h c%b z%b expected lat 2 ff c0 z0",
                  lat, bus.rsp_data, bus.rsp_carry, bus.rsp_zero);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_op;
      bit ok;
      int bad;
      logic [W-1:0] d;
      logic c, z;
      int lat;
      bus.rsp_ready = 1'b1;
      accept_cmd(OP_ADD, 8'hFF, 8'h01, ok);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      compared++;
      if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== {4'hF, 4'h1, OP_ADD}) begin
         mismatched++;
         $display("FAIL fix_drive: got %h/%h/%b expected f/1/000", bus.alu_a, bus.alu_b, bus.alu_sel);
      end
      rst = 1'b1;
      #1;
      compared++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_zero, bus.alu_sel}
          !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'b111}) begin
         mismatched++;
         $display("FAIL midop_reset: got rdy%b vld%b %h c%b z%b sel%b expected rdy1 vld0 00 c0 z0 sel111",
                  bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_zero, bus.alu_sel);
      end
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid !== 1'b0) bad++;
      end
      #2;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid !== 1'b0) bad++;
      end
      compared++;
      if (bad !== 0) begin
         mismatched++;
         $display("FAIL midop_no_rsp: got %0d cycles with rsp_valid expected 0", bad);
      end
      run_op(OP_ADD, 8'h01, 8'h01, d, c, z, lat);
      compared++;
      if ({d, c, z} !== {8'h02, 1'b0, 1'b0} || lat !== 2) begin
         mismatched++;
         $display("FAIL after_reset_add: got %h c%b z%b lat %0d expected 02 c0 z0 lat 2", d, c, z, lat);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_back_to_back();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Initiator side of the team's 4-bit combinational ALU interface.
- Accepts wide operations (NIBBLES×4 bits) over a valid/ready command port.
- Issues them to an external 4-bit ALU one nibble per cycle, LSB first, and chains carry/borrow with extra correction passes.
- Returns the wide result and final carry over a valid/ready response port.

Parameters:
- NIBBLES, 2, operand width in nibbles; data width W = 4*NIBBLES; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, others reserved
- cmd_a  in  W  operand A
- cmd_b  in  W  operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  W  result
- rsp_carry  out  1  final carry (ADD) or borrow (SUB); 0 for other ops
- rsp_zero  out  1  rsp_data == 0
- alu_a  out  4  ALU operand A
- alu_b  out  4  ALU operand B
- alu_sel  out  3  ALU select
- alu_out  in  4  ALU result (combinational from alu_a/alu_b/alu_sel)
- alu_carry  in  1  ALU carry/borrow flag

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high; clock port clk, reset port rst.
- Reset values:
  - state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_carry=0; rsp_zero=0.
  - Internal nibble index=0; pending carry=0.
- ALU drive when not in PASS/FIX: alu_a=0, alu_b=0, alu_sel=3'b111. The ALU returns 0/0 for that select.
- States: IDLE, PASS, FIX, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: register op, a, b; clear index and pending carry; go to PASS.
- PASS (one cycle per nibble i):
  - Drive alu_a=a[4i+3:4i], alu_b=b[4i+3:4i], alu_sel=op.
  - At clock edge, store alu_out into result nibble i; latch c1=alu_carry.
  - If op is ADD/SUB and pending carry=1: go to FIX.
  - Otherwise: pending carry←c1; if i==NIBBLES-1 go to DONE, else i←i+1 and stay in PASS.
- FIX (ADD/SUB only):
  - Drive alu_a=result nibble i, alu_b=4'h1, alu_sel=op.
  - At clock edge, result nibble i←alu_out; pending carry←c1|alu_carry (never both 1).
  - Then advance i, or go to DONE if this was the last nibble.
- Logic and reserved ops never take FIX; pending carry is forced to 0.
- DONE:
  - rsp_valid=1; rsp_data, rsp_carry (=pending carry for ADD/SUB, else 0) and rsp_zero are held stable.
  - On rsp_ready: go to IDLE.
  - Backpressure may last indefinitely; no output may change while stalled.
- Latency: accept edge → rsp_valid high after (NIBBLES + number of FIX passes) cycles. Minimum NIBBLES, maximum 2*NIBBLES−1.
- Throughput: one command in flight. cmd_ready=0 in PASS/FIX/DONE; a new command can be accepted no earlier than the cycle after the rsp handshake.
- Wrap: ADD/SUB results are modulo 2^W; overflow is signalled only via rsp_carry.
- Reserved op: every pass yields 0, so rsp_data=0, rsp_carry=0, rsp_zero=1.
- Reset mid-operation: immediate return to the reset values; the in-flight command is discarded and no response is produced.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Shared package (alu_pkg):
  - Op-code constants OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR and OP_NOP=3'b111.
  - State enum for IDLE/PASS/FIX/DONE.
  - Nibble width constant 4.
- No sub-module: the block is a single FSM plus a datapath register. The ALU itself is instantiated beside it, at the testbench/top level.

Test Plan:
- NIBBLES=2, ADD 0x3C+0x0F:
  - response 0x4B, carry=0, zero=0.
  - Exactly 3 ALU passes (C+F, 3+0, fix 3+1); rsp_valid 3 cycles after accept.
- ADD 0xFF+0x01: response 0x00, carry=1, zero=1; passes F+1, F+0, fix F+1; latency 3.
- SUB:
  - 0x10−0x01 → 0x0F, carry=0.
  - 0x00−0x01 → 0xFF, carry(borrow)=1.
  - 0x35−0x12 → 0x23, carry=0, latency 2 (no FIX).
- XOR 0xA5^0xFF → 0x5A, carry=0, latency 2; reserved op 3'b101 on 0xFF,0xFF → 0x00, carry=0, zero=1.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid. Required response:
  - rsp_* stable and cmd_ready=0 throughout.
  - Assert rsp_ready → IDLE next cycle; back-to-back second command accepted the following cycle.
- Reset mid-op: assert rst during the FIX cycle of 0xFF+0x01. Required response:
  - Outputs immediately at reset values; no rsp_valid.
  - After release, 0x01+0x01 returns 0x02, carry=0.
